ddr_dma_cmd_arbiter: RTL and testbench
======================================

Name: ddr_dma_cmd_arbiter

Overview:
- Shares one DDR4 datamover command port between NUM_REQ DMA requesters, using round-robin arbitration.
- Forwards each accepted request as a tagged command (tag = requester index).
- Tracks outstanding commands per requester and routes completion status back to the owner.
- Sits between the DMA client logic and the datamover/MIG path inside the system block design.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 40: DDR byte address width.
- LEN_W, 23: transfer length in bytes.
- MAX_OUTST, 4: max outstanding commands per requester (1..15).
- TAG_W, $clog2(NUM_REQ): derived, not overridable.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  request accepted (one-hot pulse).
- req_addr  in  NUM_REQ*ADDR_W  packed start addresses.
- req_len  in  NUM_REQ*LEN_W  packed byte lengths.
- req_write  in  NUM_REQ  1 = write to DDR (S2MM), 0 = read (MM2S).
- cmd_valid  out  1  command to datamover.
- cmd_ready  in  1  datamover accepts command.
- cmd_addr  out  ADDR_W  command address.
- cmd_len  out  LEN_W  command length.
- cmd_write  out  1  command direction.
- cmd_tag  out  TAG_W  owning requester index.
- sts_valid  in  1  completion status strobe.
- sts_tag  in  TAG_W  tag of the completed command.
- sts_error  in  1  completion had an error.
- done_valid  out  NUM_REQ  one-cycle completion pulse, per requester.
- done_error  out  NUM_REQ  error qualifier for done_valid.
- busy  out  1  any command outstanding, or FSM not in IDLE.
- unexpected_sts  out  1  sticky: status arrived for a tag with zero outstanding.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - FSM = IDLE; rr pointer = 0; all outstanding counters = 0.
  - All outputs 0, including unexpected_sts.
  - Status arriving after reset for pre-reset commands sets unexpected_sts.
- Eligibility: requester i is eligible when req_valid[i]=1 and outst[i] < MAX_OUTST.
- FSM states:
  - IDLE: if any requester is eligible, the winner is the first eligible index at or after ptr (wrapping).
    - req_ready[winner]=1 combinationally this cycle; addr/len/write/tag are captured.
    - ptr <= winner+1 mod NUM_REQ.
    - Next state is ISSUE, or REJECT if req_len=0.
  - ISSUE: cmd_valid=1 with registered fields, held stable until cmd_ready.
    - On cmd_valid&&cmd_ready: outst[tag]++ and return to IDLE.
    - cmd_valid rises exactly 1 cycle after the req_ready pulse.
    - Peak rate is 1 command per 2 cycles.
  - REJECT: zero-length request, no command issued.
    - Assert done_valid[tag]=1 and done_error[tag]=1 for one cycle, then go to IDLE.
    - If sts_valid targets the same tag that cycle, stay in REJECT, report the status first, and report the reject on the next free cycle.
- Status handling (any state, every cycle):
  - If sts_valid and outst[sts_tag]>0: outst[sts_tag]--; done_valid[sts_tag]=1 and done_error[sts_tag]=sts_error on the next cycle (registered, latency 1).
  - If outst[sts_tag]=0: no done pulse, no decrement; unexpected_sts <= 1 until reset.
- Simultaneous increment (cmd handshake) and decrement (sts) on the same tag: counter unchanged.
- Counters never wrap: increment is impossible at MAX_OUTST (requester not eligible); decrement is blocked at 0.
- Requester dropping req_valid before its ready pulse is legal: it is simply not arbitrated.
- Requests must hold their fields stable while valid.
- done_valid/done_error bits for different requesters may pulse in the same cycle only from different sources (one sts, one reject).
- busy = (state != IDLE) || any outst != 0.

Decomposition:
- Package ddr_dma_pkg:
  - arb_state_t enum {IDLE, ISSUE, REJECT}.
  - dma_cmd_t struct {addr, len, write, tag} sized from package localparams ADDR_W/LEN_W.
  - Function rr_pick(valid mask, ptr) returning winner index and found flag.
- One natural sub-module: rr_arbiter (mask + pointer in, one-hot grant and index out, purely combinational), reused by future AXI port sharing.
- Outstanding counters stay in the top of this block.

Test Plan:
- Single read: req0 addr 0x1000_0000, len 4096, write 0 → req_ready[0] pulse, cmd_valid next cycle with tag 0. Hold cmd_ready low 5 cycles → fields stable. sts tag0 err0 → done_valid[0] 1 cycle later, busy drops.
- Fairness: req0..3 all valid continuously, cmd_ready=1 → tag order 0,1,2,3,0,1… every 2 cycles. After 4 grants each, requesters are masked (MAX_OUTST=4) until status returns.
- Zero length: req2 len 0 → no cmd_valid; done_valid[2]=1 and done_error[2]=1. With sts tag2 in the same REJECT cycle → sts done first, reject done next cycle.
- Collision: cmd handshake tag1 and sts tag1 in the same cycle with outst[1]=2 → outst[1] stays 2; done_valid[1] next cycle.
- Spurious status: sts_valid tag3 with outst[3]=0 → no done pulse; unexpected_sts=1 and sticky until reset_n.
- Reset mid-ISSUE: drop reset_n while cmd_valid=1 → cmd_valid, req_ready and counters go 0 immediately. Subsequent sts → unexpected_sts=1; arbitration restarts at requester 0.

Source files
------------

// File: rtl/ddr_dma_pkg.sv
// Shared types and helpers for the DDR DMA command arbiter and future AXI port sharing.
package ddr_dma_pkg;

  localparam int unsigned ADDR_W    = 40;
  localparam int unsigned LEN_W     = 23;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_TAG_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REJECT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [LEN_W-1:0]     len;
    logic                 write;
    logic [MAX_TAG_W-1:0] tag;
  } dma_cmd_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_TAG_W-1:0] idx;
  } rr_pick_t;

  // First set bit of mask at or after ptr, wrapping within the low n bits.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                       input logic [MAX_TAG_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !r.found && mask[idx[MAX_TAG_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = MAX_TAG_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: request mask and priority pointer in, one-hot grant and index out.
module rr_arbiter
  import ddr_dma_pkg::*;
#(
  parameter int unsigned  N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  rr_pick_t pick;
  logic     unused_idx_bits;

  assign pick            = rr_pick(MAX_REQ'(mask_i), MAX_TAG_W'(ptr_i), N);
  assign found_o         = pick.found;
  assign idx_o           = pick.idx[IDX_W-1:0];
  assign grant_o         = pick.found ? (N'(1) << idx_o) : '0;
  assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/ddr_dma_cmd_arbiter.sv
// Round-robin sharing of one datamover command port between NUM_REQ DMA requesters,
// with per-requester outstanding tracking and tagged completion routing.
module ddr_dma_cmd_arbiter
  import ddr_dma_pkg::arb_state_t, ddr_dma_pkg::IDLE, ddr_dma_pkg::ISSUE, ddr_dma_pkg::REJECT;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  ADDR_W    = 40,
  parameter int unsigned  LEN_W     = 23,
  parameter int unsigned  MAX_OUTST = 4,
  localparam int unsigned TAG_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [LEN_W-1:0]          cmd_len,
  output logic                      cmd_write,
  output logic [TAG_W-1:0]          cmd_tag,
  input  logic                      sts_valid,
  input  logic [TAG_W-1:0]          sts_tag,
  input  logic                      sts_error,
  output logic [NUM_REQ-1:0]        done_valid,
  output logic [NUM_REQ-1:0]        done_error,
  output logic                      busy,
  output logic                      unexpected_sts
);

  localparam int unsigned CNT_W = 4;

  arb_state_t         state_q, state_d;
  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               write_q, write_d;
  logic [CNT_W-1:0]   outst_q [NUM_REQ];
  logic [CNT_W-1:0]   outst_d [NUM_REQ];
  logic [NUM_REQ-1:0] done_v_q, done_v_d, done_e_q, done_e_d;
  logic               unexp_q, unexp_d;

  logic [NUM_REQ-1:0] eligible, grant, inc, dec, rej_pulse;
  logic [TAG_W-1:0]   win_idx;
  logic               win_found, any_outst, rej_hold, rej_fire;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .mask_i  (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  always_comb begin
    eligible  = '0;
    inc       = '0;
    dec       = '0;
    any_outst = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
      inc[i]      = (state_q == ISSUE) && cmd_ready && (tag_q == TAG_W'(i));
      dec[i]      = sts_valid && (sts_tag == TAG_W'(i)) && (outst_q[i] != '0);
      outst_d[i]  = outst_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
      any_outst   = any_outst || (outst_q[i] != '0);
    end
    done_v_d = dec;
    done_e_d = dec & {NUM_REQ{sts_error}};
    unexp_d  = unexp_q || (sts_valid && (dec == '0));
  end

  // A reject yields to a status for the same tag arriving now or still being reported.
  assign rej_hold  = (sts_valid && (sts_tag == tag_q)) || done_v_q[tag_q];
  assign rej_fire  = (state_q == REJECT) && !rej_hold;
  assign rej_pulse = rej_fire ? (NUM_REQ'(1) << tag_q) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d   = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
          tag_d   = win_idx;
          addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          len_d   = req_len[win_idx*LEN_W +: LEN_W];
          write_d = req_write[win_idx];
          state_d = (req_len[win_idx*LEN_W +: LEN_W] == '0) ? REJECT : ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = IDLE;
      end
      REJECT: begin
        if (!rej_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
      done_v_q <= '0;
      done_e_q <= '0;
      unexp_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      write_q  <= write_d;
      done_v_q <= done_v_d;
      done_e_q <= done_e_d;
      unexp_q  <= unexp_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign req_ready      = (state_q == IDLE) ? grant : '0;
  assign cmd_valid      = (state_q == ISSUE);
  assign cmd_addr       = addr_q;
  assign cmd_len        = len_q;
  assign cmd_write      = write_q;
  assign cmd_tag        = tag_q;
  assign done_valid     = done_v_q | rej_pulse;
  assign done_error     = done_e_q | rej_pulse;
  assign busy           = (state_q != IDLE) || any_outst;
  assign unexpected_sts = unexp_q;

endmodule

// File: tb/tb_ddr_dma_cmd_arbiter.sv
// Directed self-checking bench for ddr_dma_cmd_arbiter with default parameters.
module tb_ddr_dma_cmd_arbiter;

  localparam int NR = 4;
  localparam int AW = 40;
  localparam int LW = 23;
  localparam int TW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid, req_ready, req_write, done_valid, done_error;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [LW-1:0]    cmd_len;
  logic [TW-1:0]    cmd_tag, sts_tag;
  logic             sts_valid, sts_error, busy, unexpected_sts;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp4;

  always #5 clk = ~clk;

  ddr_dma_cmd_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_W    (AW),
    .LEN_W     (LW),
    .MAX_OUTST (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_write      (req_write),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_write      (cmd_write),
    .cmd_tag        (cmd_tag),
    .sts_valid      (sts_valid),
    .sts_tag        (sts_tag),
    .sts_error      (sts_error),
    .done_valid     (done_valid),
    .done_error     (done_error),
    .busy           (busy),
    .unexpected_sts (unexpected_sts)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req_write[i]         = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    cmd_ready = 1'b0;
    sts_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_write = '0;
    cmd_ready = 1'b0;
    sts_valid = 1'b0;
    sts_tag   = '0;
    sts_error = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'h0);
    chk("rst_done_valid", 64'(done_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_unexp", 64'(unexpected_sts), 64'h0);
    @(negedge clk); reset_n = 1'b1;

    // Single read with back-pressure
    @(negedge clk);
    set_req(0, 40'h00_1000_0000, 23'd4096, 1'b0);
    req_valid = 4'b0001; #1;
    chk("rd_ready", 64'(req_ready), 64'h1);
    chk("rd_cv_pre", 64'(cmd_valid), 64'h0);
    @(negedge clk); req_valid = '0; #1;
    chk("rd_cv", 64'(cmd_valid), 64'h1);
    chk("rd_tag", 64'(cmd_tag), 64'h0);
    chk("rd_addr", 64'(cmd_addr), 64'h1000_0000);
    chk("rd_len", 64'(cmd_len), 64'd4096);
    chk("rd_write", 64'(cmd_write), 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("hold_cv", 64'(cmd_valid), 64'h1);
      chk("hold_addr", 64'(cmd_addr), 64'h1000_0000);
      chk("hold_len", 64'(cmd_len), 64'd4096);
    end
    @(negedge clk); cmd_ready = 1'b1; #1;
    chk("rd_cv_hs", 64'(cmd_valid), 64'h1);
    @(negedge clk); cmd_ready = 1'b0;
    sts_valid = 1'b1; sts_tag = 2'd0; sts_error = 1'b0; #1;
    chk("rd_cv_after", 64'(cmd_valid), 64'h0);
    chk("rd_busy_outst", 64'(busy), 64'h1);
    chk("rd_dv_same", 64'(done_valid), 64'h0);
    @(negedge clk); sts_valid = 1'b0; #1;
    chk("rd_dv", 64'(done_valid), 64'h1);
    chk("rd_de", 64'(done_error), 64'h0);
    chk("rd_busy_low", 64'(busy), 64'h0);
    @(negedge clk); #1;
    chk("rd_dv_once", 64'(done_valid), 64'h0);

    // Fairness and outstanding limit
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, {8'h20, 32'(i)}, 23'd64, 1'b0);
    @(negedge clk); req_valid = 4'hF; cmd_ready = 1'b1; #1;
    for (int g = 0; g < 16; g++) begin
      exp4 = 4'b0001 << (g % 4);
      chk("fair_ready", 64'(req_ready), 64'(exp4));
      @(negedge clk); #1;
      chk("fair_cv", 64'(cmd_valid), 64'h1);
      chk("fair_tag", 64'(cmd_tag), 64'(g % 4));
      @(negedge clk); #1;
    end
    chk("full_ready", 64'(req_ready), 64'h0);
    chk("full_cv", 64'(cmd_valid), 64'h0);
    chk("full_busy", 64'(busy), 64'h1);
    @(negedge clk);
    sts_valid = 1'b1; sts_tag = 2'd2; sts_error = 1'b1; #1;
    chk("full_ready2", 64'(req_ready), 64'h0);
    @(negedge clk); sts_valid = 1'b0; #1;
    chk("full_sts_dv", 64'(done_valid), 64'h4);
    chk("full_sts_de", 64'(done_error), 64'h4);
    chk("full_regrant", 64'(req_ready), 64'h4);
    @(negedge clk); req_valid = '0; #1;
    chk("full_cv2", 64'(cmd_valid), 64'h1);
    chk("full_tag2", 64'(cmd_tag), 64'h2);

    // Increment and decrement on the same tag in one cycle
    do_reset();
    @(negedge clk);
    set_req(1, 40'h30_0000_0000, 23'd128, 1'b1);
    req_valid = 4'b0010; cmd_ready = 1'b1; #1;
    chk("col_rdy0", 64'(req_ready), 64'h2);
    @(negedge clk); #1;
    chk("col_cv0", 64'(cmd_valid), 64'h1);
    chk("col_write", 64'(cmd_write), 64'h1);
    @(negedge clk); #1;
    chk("col_rdy1", 64'(req_ready), 64'h2);
    @(negedge clk); #1;
    chk("col_cv1", 64'(cmd_valid), 64'h1);
    @(negedge clk); #1;
    chk("col_rdy2", 64'(req_ready), 64'h2);
    @(negedge clk); req_valid = '0;
    sts_valid = 1'b1; sts_tag = 2'd1; sts_error = 1'b0; #1;
    chk("col_cv2", 64'(cmd_valid), 64'h1);
    chk("col_tag2", 64'(cmd_tag), 64'h1);
    @(negedge clk); #1;
    chk("col_dv", 64'(done_valid), 64'h2);
    chk("col_de", 64'(done_error), 64'h0);
    @(negedge clk); #1;
    chk("col_dv2", 64'(done_valid), 64'h2);
    chk("col_busy", 64'(busy), 64'h1);
    @(negedge clk); sts_valid = 1'b0; #1;
    chk("col_dv3", 64'(done_valid), 64'h2);
    chk("col_busy_low", 64'(busy), 64'h0);
    chk("col_unexp", 64'(unexpected_sts), 64'h0);

    // Spurious status
    @(negedge clk); sts_valid = 1'b1; sts_tag = 2'd3; #1;
    @(negedge clk); sts_valid = 1'b0; #1;
    chk("sp_dv", 64'(done_valid), 64'h0);
    chk("sp_unexp", 64'(unexpected_sts), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    chk("sp_sticky", 64'(unexpected_sts), 64'h1);
    do_reset(); #1;
    chk("sp_cleared", 64'(unexpected_sts), 64'h0);

    // Zero-length reject
    @(negedge clk);
    set_req(2, 40'h40_0000_0000, 23'd0, 1'b0);
    req_valid = 4'b0100; cmd_ready = 1'b1; #1;
    chk("zl_ready", 64'(req_ready), 64'h4);
    @(negedge clk); req_valid = '0; #1;
    chk("zl_cv", 64'(cmd_valid), 64'h0);
    chk("zl_dv", 64'(done_valid), 64'h4);
    chk("zl_de", 64'(done_error), 64'h4);
    chk("zl_busy", 64'(busy), 64'h1);
    @(negedge clk); #1;
    chk("zl_dv_once", 64'(done_valid), 64'h0);
    chk("zl_busy_low", 64'(busy), 64'h0);

    // Zero-length reject colliding with a status for the same requester
    @(negedge clk);
    set_req(2, 40'h40_0000_0000, 23'd256, 1'b0);
    req_valid = 4'b0100; #1;
    chk("zc_rdy_real", 64'(req_ready), 64'h4);
    @(negedge clk);
    set_req(2, 40'h40_0000_0000, 23'd0, 1'b0); #1;
    chk("zc_cv_real", 64'(cmd_valid), 64'h1);
    @(negedge clk); #1;
    chk("zc_rdy_zero", 64'(req_ready), 64'h4);
    @(negedge clk); req_valid = '0;
    sts_valid = 1'b1; sts_tag = 2'd2; sts_error = 1'b0; #1;
    chk("zc_dv_held", 64'(done_valid), 64'h0);
    chk("zc_cv", 64'(cmd_valid), 64'h0);
    @(negedge clk); sts_valid = 1'b0; #1;
    chk("zc_sts_dv", 64'(done_valid), 64'h4);
    chk("zc_sts_de", 64'(done_error), 64'h0);
    @(negedge clk); #1;
    chk("zc_rej_dv", 64'(done_valid), 64'h4);
    chk("zc_rej_de", 64'(done_error), 64'h4);
    @(negedge clk); #1;
    chk("zc_dv_end", 64'(done_valid), 64'h0);
    chk("zc_busy_end", 64'(busy), 64'h0);

    // Reset while a command is pending
    @(negedge clk);
    set_req(1, 40'h50_0000_0000, 23'd16, 1'b1);
    req_valid = 4'b0010; cmd_ready = 1'b1; #1;
    chk("mr_rdy0", 64'(req_ready), 64'h2);
    @(negedge clk); #1;
    chk("mr_cv0", 64'(cmd_valid), 64'h1);
    @(negedge clk); cmd_ready = 1'b0; #1;
    chk("mr_rdy1", 64'(req_ready), 64'h2);
    @(negedge clk); req_valid = '0; #1;
    chk("mr_cv1", 64'(cmd_valid), 64'h1);
    chk("mr_busy", 64'(busy), 64'h1);
    #2; reset_n = 1'b0; #1;
    chk("mr_cv_rst", 64'(cmd_valid), 64'h0);
    chk("mr_rdy_rst", 64'(req_ready), 64'h0);
    chk("mr_busy_rst", 64'(busy), 64'h0);
    chk("mr_dv_rst", 64'(done_valid), 64'h0);
    @(negedge clk); reset_n = 1'b1;
    sts_valid = 1'b1; sts_tag = 2'd1; sts_error = 1'b0; #1;
    @(negedge clk); sts_valid = 1'b0;
    set_req(0, 40'h60_0000_0000, 23'd32, 1'b0);
    set_req(3, 40'h70_0000_0000, 23'd32, 1'b0);
    req_valid = 4'b1011; #1;
    chk("mr_unexp", 64'(unexpected_sts), 64'h1);
    chk("mr_dv", 64'(done_valid), 64'h0);
    chk("mr_restart", 64'(req_ready), 64'h1);
    @(negedge clk); req_valid = '0; #1;
    chk("mr_cv2", 64'(cmd_valid), 64'h1);
    chk("mr_tag2", 64'(cmd_tag), 64'h0);
    chk("mr_addr2", 64'(cmd_addr), 64'h60_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
